// File: rtl/cache_block_responder.sv
// Memory-side responder for cache block refills (read bursts) and write-backs (write bursts).
// Optional macro CACHE_RESP_ERR_EN adds o_resp_err for transfers addressed beyond the backing store.
module cache_block_responder #(
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           i_start_read,
    input  logic                           i_start_write,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    input  logic [WORD_WIDTH-1:0]          i_w_data,
    output logic                           o_w_ready,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_beat_idx,
    output logic [WORD_WIDTH-1:0]          o_r_data,
    output logic                           o_r_valid,
    output logic                           o_r_last,
    output logic                           o_b_resp
`ifdef CACHE_RESP_ERR_EN
    ,
    output logic                           o_resp_err
`endif
);

    localparam int unsigned BEAT_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned MEM_AW  = $clog2(MEM_WORDS);
    localparam int unsigned BLK_W   = MEM_AW - BEAT_W;
    localparam int unsigned OFF_W   = $clog2(WORD_WIDTH / 8);
    localparam int unsigned BLK_LSB = OFF_W + BEAT_W;
    localparam int unsigned LAT_W   = $clog2(RD_LATENCY + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_BURST = 3'd3,
        WR_RESP  = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic                  w_ready_q, w_ready_d;
    logic                  r_valid_q, r_valid_d;
    logic                  r_last_q, r_last_d;
    logic                  b_resp_q, b_resp_d;
    logic [WORD_WIDTH-1:0] r_data_q, r_data_d;
    logic                  mem_we_c;
    logic                  drop_c;
    logic [WORD_WIDTH-1:0] mem_q [MEM_WORDS];

`ifdef CACHE_RESP_ERR_EN
    localparam int unsigned BYTE_AW = MEM_AW + OFF_W;
    logic err_q, err_d;
    logic resp_err_q, resp_err_d;
    logic addr_err_c;

    assign addr_err_c = (i_addr >> BYTE_AW) != '0;
    assign drop_c     = err_q;
`else
    assign drop_c     = 1'b0;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        beat_d    = '0;
        lat_d     = '0;
        blk_d     = blk_q;
        w_ready_d = 1'b0;
        r_valid_d = 1'b0;
        r_last_d  = 1'b0;
        b_resp_d  = 1'b0;
        r_data_d  = '0;
        mem_we_c  = 1'b0;
`ifdef CACHE_RESP_ERR_EN
        err_d      = err_q;
        resp_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_start_write || i_start_read) begin
                    blk_d = BLK_W'(i_addr >> BLK_LSB);
`ifdef CACHE_RESP_ERR_EN
                    err_d = addr_err_c;
`endif
                end
                if (i_start_write) begin
                    state_d   = WR_BURST;
                    w_ready_d = 1'b1;
                end else if (i_start_read) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!i_start_read) begin
                    state_d = IDLE;
                end else if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
                    state_d   = RD_BURST;
                    r_valid_d = 1'b1;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RD_BURST: begin
                if (!i_start_read) begin
                    state_d = IDLE;
                end else if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d    = beat_q + BEAT_W'(1);
                    r_valid_d = 1'b1;
                    r_last_d  = (beat_d == LAST_BEAT);
                end
            end
            WR_BURST: begin
                if (!i_start_write) begin
                    state_d = IDLE;
                end else begin
                    mem_we_c = !drop_c;
                    if (beat_q == LAST_BEAT) begin
                        state_d  = WR_RESP;
                        b_resp_d = 1'b1;
                    end else begin
                        beat_d    = beat_q + BEAT_W'(1);
                        w_ready_d = 1'b1;
                    end
                end
            end
            WR_RESP: state_d = DONE;
            // A held start level must drop before another transfer can begin
            DONE: begin
                if (!i_start_read && !i_start_write) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (r_valid_d && !drop_c) begin
            r_data_d = mem_q[{blk_q, beat_d}];
        end
`ifdef CACHE_RESP_ERR_EN
        resp_err_d = (r_last_d || b_resp_d) && err_q;
`endif
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            blk_q     <= '0;
            w_ready_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            b_resp_q  <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            blk_q     <= blk_d;
            w_ready_q <= w_ready_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            b_resp_q  <= b_resp_d;
            r_data_q  <= r_data_d;
        end
    end

`ifdef CACHE_RESP_ERR_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_q      <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign o_resp_err = resp_err_q;
`endif

    // Backing store; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[{blk_q, beat_q}] <= i_w_data;
        end
    end

    assign o_w_ready  = w_ready_q;
    assign o_beat_idx = beat_q;
    assign o_r_data   = r_data_q;
    assign o_r_valid  = r_valid_q;
    assign o_r_last   = r_last_q;
    assign o_b_resp   = b_resp_q;

endmodule

// File: tb/tb_cache_block_responder.sv
// Testbench for cache_block_responder: transfer-level model of the store and handshake timing,
// checked every cycle, plus literal expectations. Honours CACHE_RESP_ERR_EN when defined.
module tb_cache_block_responder;

    localparam int unsigned BW = 16;
    localparam int unsigned MW = 1024;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        i_start_read = 1'b0;
    logic        i_start_write = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_w_data = 32'h0;
    logic        o_w_ready;
    logic [3:0]  o_beat_idx;
    logic [31:0] o_r_data;
    logic        o_r_valid;
    logic        o_r_last;
    logic        o_b_resp;
    logic        resp_err_w;

`ifdef CACHE_RESP_ERR_EN
    logic o_resp_err;
    assign resp_err_w = o_resp_err;
`else
    assign resp_err_w = 1'b0;
`endif

    cache_block_responder dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_start_read (i_start_read),
        .i_start_write(i_start_write),
        .i_addr       (i_addr),
        .i_w_data     (i_w_data),
        .o_w_ready    (o_w_ready),
        .o_beat_idx   (o_beat_idx),
        .o_r_data     (o_r_data),
        .o_r_valid    (o_r_valid),
        .o_r_last     (o_r_last),
        .o_b_resp     (o_b_resp)
`ifdef CACHE_RESP_ERR_EN
        ,
        .o_resp_err   (o_resp_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_mem [MW];
    int          rv_total = 0;
    int          rv_first_cyc = 0;
    logic [31:0] rv_last_data = 32'h0;
    logic        rv_last_flag = 1'b0;
    logic [31:0] rv_data [BW];
    int          acc_cyc = 0;
    int          rv_base = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Advance one cycle, then compare all outputs at the falling edge against the expectation
    task automatic step(input logic wr, input logic [3:0] bt, input logic rv, input logic [31:0] rd,
                        input logic rl, input logic br, input logic er);
        logic [63:0] got;
        logic [63:0] want;
        @(negedge clk);
        got  = {23'h0, o_w_ready, o_beat_idx, o_r_valid, o_r_last, o_b_resp, resp_err_w,
                (o_r_valid === 1'b1) ? o_r_data : 32'h0};
        want = {23'h0, wr, bt, rv, rl, br, er, rv ? rd : 32'h0};
        chk($sformatf("outputs cyc %0d", cyc), got, want);
        if (o_r_valid === 1'b1) begin
            rv_total++;
            rv_data[o_beat_idx] = o_r_data;
            rv_last_data = o_r_data;
            rv_last_flag = o_r_last;
            if (o_beat_idx == 4'd0) rv_first_cyc = cyc;
        end
    endtask

    task automatic idle_step();
        step(1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int unsigned blk_base(input logic [31:0] a);
        return (32'(a >> 2) & (MW - 1)) & ~(BW - 1);
    endfunction

    function automatic logic addr_err(input logic [31:0] a);
`ifdef CACHE_RESP_ERR_EN
        return a >= 32'(MW * 4);
`else
        return (a & 32'h0) != 32'h0;
`endif
    endfunction

    // Refill: two idle cycles, then 16 beats; start held 'hold' cycles past r_last or dropped at abort_beat
    task automatic do_read(input logic [31:0] addr, input int hold, input int abort_beat);
        int unsigned base;
        logic        err;
        base = blk_base(addr);
        err  = addr_err(addr);
        rv_base = rv_total;
        acc_cyc = cyc;
        i_addr = addr;
        i_start_read = 1'b1;
        idle_step();
        i_addr = 32'hDEAD_BEEC;
        idle_step();
        for (int b = 0; b < int'(BW); b++) begin
            step(1'b0, 4'(b), 1'b1, err ? 32'h0 : model_mem[10'(base + 32'(b))],
                 b == int'(BW) - 1, 1'b0, err && (b == int'(BW) - 1));
            if (b == abort_beat) begin
                i_start_read = 1'b0;
                idle_step();
                return;
            end
        end
        repeat (hold) idle_step();
        i_start_read = 1'b0;
        idle_step();
    endtask

    // Write-back of d0..d0+15; optional abort at a beat and optional concurrent read request
    task automatic do_write(input logic [31:0] addr, input logic [31:0] d0, input int abort_beat,
                            input logic with_read);
        int unsigned base;
        logic        err;
        base = blk_base(addr);
        err  = addr_err(addr);
        i_addr = addr;
        i_start_write = 1'b1;
        if (with_read) i_start_read = 1'b1;
        for (int b = 0; b < int'(BW); b++) begin
            step(1'b1, 4'(b), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            i_addr = 32'hDEAD_BEEC;
            if (b == abort_beat) begin
                i_start_write = 1'b0;
                idle_step();
                return;
            end
            i_w_data = d0 + 32'(b);
            if (!err) model_mem[10'(base + 32'(b))] = d0 + 32'(b);
        end
        step(1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 1'b1, err);
        i_start_write = 1'b0;
        i_w_data = 32'h0;
        idle_step();
        if (with_read) begin
            repeat (3) idle_step();
            i_start_read = 1'b0;
        end
        idle_step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        #2 arst_n = 1'b0;
        #1 chk("reset state", 64'({o_w_ready, o_beat_idx, o_r_valid, o_r_last, o_b_resp, resp_err_w}), 64'h0);
        repeat (2) idle_step();
        arst_n = 1'b1;
        idle_step();

        // Write 0x40 with 0xA0.., read it back
        do_write(32'h40, 32'hA0, -1, 1'b0);
        do_read(32'h40, 1, -1);
        chk("read latency", 64'(rv_first_cyc - acc_cyc), 64'd3);
        chk("read beat count", 64'(rv_total - rv_base), 64'd16);
        chk("first beat data", 64'(rv_data[0]), 64'hA0);
        chk("last beat data", 64'(rv_last_data), 64'hAF);
        chk("last beat flag", 64'(rv_last_flag), 64'd1);

        // Read abort at beat 5, then held start past r_last
        do_read(32'h40, 0, 5);
        chk("aborted read beats", 64'(rv_total - rv_base), 64'd6);
        do_read(32'h44, 5, -1);
        chk("held start beats", 64'(rv_total - rv_base), 64'd16);

        // Simultaneous starts: write wins
        do_write(32'h80, 32'h300, -1, 1'b1);
        do_read(32'h80, 1, -1);
        chk("prio write data", 64'(rv_data[15]), 64'h30F);

        // Async reset in the middle of a burst
        base = blk_base(32'h80);
        i_addr = 32'h80;
        i_start_read = 1'b1;
        idle_step();
        idle_step();
        for (int b = 0; b < 6; b++) begin
            step(1'b0, 4'(b), 1'b1, model_mem[10'(base + 32'(b))], 1'b0, 1'b0, 1'b0);
        end
        arst_n = 1'b0;
        i_start_read = 1'b0;
        #1 chk("reset mid-burst", 64'({o_w_ready, o_beat_idx, o_r_valid, o_r_last, o_b_resp, resp_err_w}), 64'h0);
        repeat (2) idle_step();
        arst_n = 1'b1;
        idle_step();
        do_read(32'h80, 1, -1);
        chk("read after reset beats", 64'(rv_total - rv_base), 64'd16);

        // Write-back abort at beat 7
        do_write(32'hC0, 32'hB0, -1, 1'b0);
        do_write(32'hC0, 32'hD0, 7, 1'b0);
        do_read(32'hC0, 1, -1);
        chk("abort kept beat 6", 64'(rv_data[6]), 64'hD6);
        chk("abort dropped beat 7", 64'(rv_data[7]), 64'hB7);
        chk("abort dropped beat 15", 64'(rv_data[15]), 64'hBF);

        // Address past the backing store
        do_write(32'h0, 32'hE0, -1, 1'b0);
        do_read(32'h1000, 1, -1);
`ifdef CACHE_RESP_ERR_EN
        chk("oob read last data", 64'(rv_last_data), 64'h0);
`else
        chk("wrapped read first data", 64'(rv_data[0]), 64'hE0);
        chk("wrapped read last data", 64'(rv_last_data), 64'hEF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
